mux_arb_n: RTL and testbench
============================

Name: mux_arb_n

Overview:
- Parametrised N-input, WIDTH-bit data selector with a registered output stage and valid/ready handshakes on every channel.
- Operates in one of two modes:
  - mode 0: externally selected, the generalised successor of the 2:1 datapath mux.
  - mode 1: internal round-robin arbitration.
- Used where several producers share one consumer, for example instruction/data memory request sharing or multi-cycle writeback source selection.
- Output stage is a single-entry buffer that sustains one transfer per cycle.

Parameters:
- WIDTH, 32, data width of each channel.
- N_INPUTS, 4, number of input channels; legal range 2..16.
- SEL_W, $clog2(N_INPUTS), width of select and channel index. Derived; must not be overridden.
- MODE, 0, 0 = external select, 1 = round-robin arbitration.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous active-high reset.
- in_valid  input  N_INPUTS  per-channel valid; bit i belongs to channel i.
- in_data  input  N_INPUTS*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- in_ready  output  N_INPUTS  per-channel ready, combinational.
- select_signal  input  SEL_W  channel select; used in MODE 0 only, ignored in MODE 1.
- out_valid  output  1  output register holds valid data.
- out_data  output  WIDTH  registered selected data.
- out_channel  output  SEL_W  index of the channel that produced out_data.
- out_ready  input  1  consumer accepts out_data.

Behaviour:
- Reset:
  - Single clock and reset, fixed: clk, reset synchronous and active-high.
  - Reset sampled on the rising clk edge: out_valid=0, out_data=0, out_channel=0, rr_ptr=0.
  - in_ready is all zeros for the whole cycle in which reset is high.
  - Reset mid-transfer drops the buffered word; no handshake completes in that cycle.
- Accept condition: accept = !out_valid || out_ready, so a new word may enter in the same cycle the old one leaves.
- Grant:
  - Exactly one or zero channels are granted per cycle.
  - in_ready[g] = accept when channel g is granted; all other in_ready bits are 0.
  - MODE 0: g = select_signal; the grant is independent of in_valid.
  - MODE 0: if select_signal >= N_INPUTS (N_INPUTS not a power of two), nothing is granted and in_ready is all zeros.
  - MODE 1: g = first index j scanning rr_ptr, rr_ptr+1, ... N_INPUTS-1, 0, ... rr_ptr-1 with in_valid[j]=1. No valid bit set means no grant.
  - in_ready must not depend on out_valid's next value. It may depend on in_valid in MODE 1 only.
- Transfer:
  - A transfer occurs when in_valid[g] && in_ready[g].
  - On the next edge: out_data <= in_data[g], out_channel <= g, out_valid <= 1.
  - MODE 1: rr_ptr <= (g+1) mod N_INPUTS. The wrap from N_INPUTS-1 goes to 0.
- Hold:
  - If out_valid && !out_ready, then out_data, out_channel and out_valid hold, and no input transfer occurs.
  - If out_ready && out_valid with no transfer, out_valid <= 0 and out_data and out_channel hold their last values.
- Latency and ordering:
  - One cycle from input handshake to out_valid.
  - Full throughput of one word per cycle when out_ready is held high.
  - Ordering within a channel is preserved.
- Pointer: rr_ptr changes only on a transfer in MODE 1. It stays 0 in MODE 0.
- Protocol rules:
  - Producers must hold in_data and in_valid until accepted.
  - The block never asserts in_ready on more than one bit.
- Implementation: output register plus combinational grant logic; no other state.

Test Plan:
- Reset: assert reset with in_valid=4'b1111 and out_ready=1 -> in_ready=0000, and after the edge out_valid=0, out_data=0, out_channel=0.
- MODE 0 select and backpressure:
  - Stimulus: select_signal=2, channel 2 data 32'hCAFE0002 valid, out_ready=0.
  - Cycle 1: out_valid=1, out_data=32'hCAFE0002, out_channel=2.
  - While out_ready=0 for 3 cycles: in_ready[2]=0 and the output holds.
  - Release out_ready=1: the next word transfers in the same cycle as the drain.
- MODE 0 no-grant case: N_INPUTS=3 with select_signal=3 and all channels valid -> in_ready=000 and out_valid stays 0.
- MODE 1 fairness:
  - Stimulus: all 4 channels continuously valid, out_ready=1.
  - out_channel sequence 0,1,2,3,0,1,... with one word per cycle and no bubbles.
- MODE 1 skip and wrap:
  - Stimulus: rr_ptr=3 after a grant to channel 2, with only channels 1 and 3 valid.
  - Grant order is 3, then 1, then 3.
  - Bubble case: channel 3 valid only while rr_ptr=0 -> granted, and rr_ptr wraps to 0.
- Reset mid-operation: out_valid=1 with out_ready=0, then assert reset for 1 cycle -> out_valid=0 and rr_ptr=0. The first grant after reset in MODE 1 goes to the lowest valid channel.

Source files
------------

// File: rtl/mux_arb_n.sv
// N-input WIDTH-bit data selector with a single-entry registered output stage.
// MODE 0 picks the channel from select_signal; MODE 1 arbitrates round-robin.
module mux_arb_n #(
   parameter int unsigned WIDTH    = 32,
   parameter int unsigned N_INPUTS = 4,
   parameter int unsigned SEL_W    = $clog2(N_INPUTS),
   parameter int unsigned MODE     = 0
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [N_INPUTS-1:0]       in_valid,
   input  logic [N_INPUTS*WIDTH-1:0] in_data,
   output logic [N_INPUTS-1:0]       in_ready,
   input  logic [SEL_W-1:0]          select_signal,
   output logic                      out_valid,
   output logic [WIDTH-1:0]          out_data,
   output logic [SEL_W-1:0]          out_channel,
   input  logic                      out_ready
);

   logic [WIDTH-1:0] ch_data [N_INPUTS];

   logic             out_valid_q, out_valid_d;
   logic [WIDTH-1:0] out_data_q, out_data_d;
   logic [SEL_W-1:0] out_channel_q, out_channel_d;
   logic [SEL_W-1:0] rr_ptr_q, rr_ptr_d;

   logic             grant_vld;
   logic [SEL_W-1:0] grant_idx;
   logic             accept;
   logic             xfer;
   int unsigned      scan_idx;

   for (genvar i = 0; i < N_INPUTS; i++) begin : g_unpack
      assign ch_data[i] = in_data[i*WIDTH +: WIDTH];
   end

   // Grant selection: external select, or first valid channel at/after rr_ptr.
   always_comb begin
      grant_vld = 1'b0;
      grant_idx = '0;
      scan_idx  = 0;
      if (MODE == 0) begin
         if (32'(select_signal) < N_INPUTS) begin
            grant_vld = 1'b1;
            grant_idx = select_signal;
         end
      end else begin
         for (int unsigned k = 0; k < N_INPUTS; k++) begin
            scan_idx = 32'(rr_ptr_q) + k;
            if (scan_idx >= N_INPUTS) scan_idx = scan_idx - N_INPUTS;
            if (!grant_vld && in_valid[SEL_W'(scan_idx)]) begin
               grant_vld = 1'b1;
               grant_idx = SEL_W'(scan_idx);
            end
         end
      end
   end

   // The buffer can take a word when empty or draining this cycle.
   assign accept = !out_valid_q || out_ready;

   always_comb begin
      in_ready = '0;
      if (!reset && grant_vld && accept) in_ready[grant_idx] = 1'b1;
   end

   assign xfer = !reset && grant_vld && accept && in_valid[grant_idx];

   always_comb begin
      out_valid_d   = out_valid_q;
      out_data_d    = out_data_q;
      out_channel_d = out_channel_q;
      rr_ptr_d      = rr_ptr_q;
      if (xfer) begin
         out_valid_d   = 1'b1;
         out_data_d    = ch_data[grant_idx];
         out_channel_d = grant_idx;
         if (MODE == 1) begin
            rr_ptr_d = (grant_idx == SEL_W'(N_INPUTS - 1)) ? '0 : SEL_W'(grant_idx + SEL_W'(1));
         end
      end else if (out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         out_valid_q   <= 1'b0;
         out_data_q    <= '0;
         out_channel_q <= '0;
         rr_ptr_q      <= '0;
      end else begin
         out_valid_q   <= out_valid_d;
         out_data_q    <= out_data_d;
         out_channel_q <= out_channel_d;
         rr_ptr_q      <= rr_ptr_d;
      end
   end

   assign out_valid   = out_valid_q;
   assign out_data    = out_data_q;
   assign out_channel = out_channel_q;

endmodule

// File: tb/tb_mux_arb_n.sv
// Directed bench for mux_arb_n: MODE 0 with 4 and 3 inputs, MODE 1 with 4 inputs.
module tb_mux_arb_n;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   // DUT A: MODE 0, N=4
   logic [3:0]   a_valid, a_rdy, a_sel_dummy;
   logic [127:0] a_data;
   logic [1:0]   a_sel, a_oc;
   logic         a_ov, a_ordy;
   logic [31:0]  a_od;
   // DUT B: MODE 0, N=3
   logic [2:0]   b_valid, b_rdy;
   logic [95:0]  b_data;
   logic [1:0]   b_sel, b_oc;
   logic         b_ov, b_ordy;
   logic [31:0]  b_od;
   // DUT C: MODE 1, N=4
   logic [3:0]   c_valid, c_rdy;
   logic [127:0] c_data;
   logic [1:0]   c_sel, c_oc;
   logic         c_ov, c_ordy;
   logic [31:0]  c_od;

   mux_arb_n #(.WIDTH(32), .N_INPUTS(4), .MODE(0)) u_a (
      .clk(clk), .reset(reset), .in_valid(a_valid), .in_data(a_data), .in_ready(a_rdy),
      .select_signal(a_sel), .out_valid(a_ov), .out_data(a_od), .out_channel(a_oc),
      .out_ready(a_ordy));
   mux_arb_n #(.WIDTH(32), .N_INPUTS(3), .MODE(0)) u_b (
      .clk(clk), .reset(reset), .in_valid(b_valid), .in_data(b_data), .in_ready(b_rdy),
      .select_signal(b_sel), .out_valid(b_ov), .out_data(b_od), .out_channel(b_oc),
      .out_ready(b_ordy));
   mux_arb_n #(.WIDTH(32), .N_INPUTS(4), .MODE(1)) u_c (
      .clk(clk), .reset(reset), .in_valid(c_valid), .in_data(c_data), .in_ready(c_rdy),
      .select_signal(c_sel), .out_valid(c_ov), .out_data(c_od), .out_channel(c_oc),
      .out_ready(c_ordy));

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", nm, got, exp);
      end
   endtask

   typedef struct {
      logic [1:0]  sel;
      logic [3:0]  valid;
      logic        ordy;
      logic [7:0]  tag;
      logic [3:0]  exp_rdy;
      logic        exp_ov;
      logic [31:0] exp_od;
      logic [1:0]  exp_oc;
   } vec0_t;

   typedef struct {
      logic [3:0] valid;
      logic       ordy;
      logic [3:0] exp_rdy;
      logic       exp_ov;
      logic [1:0] exp_oc;
   } vec1_t;

   vec0_t va[10];
   vec1_t vc[19];

   initial begin
      // MODE 0 vectors; channel c data = CAFE0000 + tag*256 + c
      va[0] = '{2'd2, 4'b0100, 1'b0, 8'd0, 4'b0100, 1'b1, 32'hCAFE0002, 2'd2};
      va[1] = '{2'd2, 4'b0100, 1'b0, 8'd1, 4'b0000, 1'b1, 32'hCAFE0002, 2'd2};
      va[2] = '{2'd2, 4'b0100, 1'b0, 8'd1, 4'b0000, 1'b1, 32'hCAFE0002, 2'd2};
      va[3] = '{2'd2, 4'b0100, 1'b0, 8'd1, 4'b0000, 1'b1, 32'hCAFE0002, 2'd2};
      va[4] = '{2'd2, 4'b0100, 1'b1, 8'd1, 4'b0100, 1'b1, 32'hCAFE0102, 2'd2};
      va[5] = '{2'd1, 4'b0000, 1'b1, 8'd2, 4'b0010, 1'b0, 32'hCAFE0102, 2'd2};
      va[6] = '{2'd3, 4'b1000, 1'b0, 8'd3, 4'b1000, 1'b1, 32'hCAFE0303, 2'd3};
      va[7] = '{2'd0, 4'b0001, 1'b1, 8'd4, 4'b0001, 1'b1, 32'hCAFE0400, 2'd0};
      va[8] = '{2'd0, 4'b0000, 1'b0, 8'd5, 4'b0000, 1'b1, 32'hCAFE0400, 2'd0};
      va[9] = '{2'd1, 4'b1111, 1'b1, 8'd6, 4'b0010, 1'b1, 32'hCAFE0601, 2'd1};

      // MODE 1: fairness, skip/wrap, bubble wrap, backpressure
      vc[0]  = '{4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0};
      vc[1]  = '{4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1};
      vc[2]  = '{4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2};
      vc[3]  = '{4'b1111, 1'b1, 4'b1000, 1'b1, 2'd3};
      vc[4]  = '{4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0};
      vc[5]  = '{4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1};
      vc[6]  = '{4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2};
      vc[7]  = '{4'b1111, 1'b1, 4'b1000, 1'b1, 2'd3};
      vc[8]  = '{4'b0100, 1'b1, 4'b0100, 1'b1, 2'd2};
      vc[9]  = '{4'b1010, 1'b1, 4'b1000, 1'b1, 2'd3};
      vc[10] = '{4'b1010, 1'b1, 4'b0010, 1'b1, 2'd1};
      vc[11] = '{4'b1010, 1'b1, 4'b1000, 1'b1, 2'd3};
      vc[12] = '{4'b1000, 1'b1, 4'b1000, 1'b1, 2'd3};
      vc[13] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd3};
      vc[14] = '{4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0};
      vc[15] = '{4'b1111, 1'b0, 4'b0000, 1'b1, 2'd0};
      vc[16] = '{4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1};
      vc[17] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd1};
      vc[18] = '{4'b0100, 1'b0, 4'b0100, 1'b1, 2'd2};

      a_sel_dummy = '0;
      for (int c = 0; c < 4; c++) begin
         a_data[c*32 +: 32] = 32'hCAFE0000 + 32'(c);
         c_data[c*32 +: 32] = 32'hD0000000 + 32'(c);
      end
      for (int c = 0; c < 3; c++) b_data[c*32 +: 32] = 32'hB0000000 + 32'(c);

      // Reset with everything valid and ready
      reset = 1'b1;
      a_valid = 4'b1111; a_sel = 2'd2; a_ordy = 1'b1;
      b_valid = 3'b111;  b_sel = 2'd0; b_ordy = 1'b1;
      c_valid = 4'b1111; c_sel = 2'd0; c_ordy = 1'b1;
      #1;
      chk("reset a in_ready", 32'(a_rdy), 32'h0);
      chk("reset b in_ready", 32'(b_rdy), 32'h0);
      chk("reset c in_ready", 32'(c_rdy), 32'h0);
      @(posedge clk); #1;
      chk("reset a out_valid", 32'(a_ov), 32'h0);
      chk("reset a out_data", a_od, 32'h0);
      chk("reset a out_channel", 32'(a_oc), 32'h0);
      chk("reset c out_valid", 32'(c_ov), 32'h0);
      reset = 1'b0;
      a_valid = '0; b_valid = '0; c_valid = '0;

      // MODE 0 table
      for (int i = 0; i < 10; i++) begin
         a_sel = va[i].sel; a_valid = va[i].valid; a_ordy = va[i].ordy;
         for (int c = 0; c < 4; c++)
            a_data[c*32 +: 32] = 32'hCAFE0000 + (32'(va[i].tag) << 8) + 32'(c);
         #1;
         chk($sformatf("A%0d in_ready", i), 32'(a_rdy), 32'(va[i].exp_rdy));
         @(posedge clk); #1;
         chk($sformatf("A%0d out_valid", i), 32'(a_ov), 32'(va[i].exp_ov));
         chk($sformatf("A%0d out_data", i), a_od, va[i].exp_od);
         chk($sformatf("A%0d out_channel", i), 32'(a_oc), 32'(va[i].exp_oc));
      end
      a_valid = '0;

      // MODE 0, N=3: out-of-range select grants nothing
      b_sel = 2'd3; b_valid = 3'b111; b_ordy = 1'b1;
      for (int i = 0; i < 2; i++) begin
         #1;
         chk($sformatf("B%0d in_ready sel3", i), 32'(b_rdy), 32'h0);
         @(posedge clk); #1;
         chk($sformatf("B%0d out_valid sel3", i), 32'(b_ov), 32'h0);
      end
      b_sel = 2'd2;
      #1;
      chk("B in_ready sel2", 32'(b_rdy), 32'h4);
      @(posedge clk); #1;
      chk("B out_valid sel2", 32'(b_ov), 32'h1);
      chk("B out_data sel2", b_od, 32'hB0000002);
      chk("B out_channel sel2", 32'(b_oc), 32'h2);
      b_valid = '0;

      // MODE 1 table
      for (int i = 0; i < 19; i++) begin
         c_valid = vc[i].valid; c_ordy = vc[i].ordy;
         #1;
         chk($sformatf("C%0d in_ready", i), 32'(c_rdy), 32'(vc[i].exp_rdy));
         @(posedge clk); #1;
         chk($sformatf("C%0d out_valid", i), 32'(c_ov), 32'(vc[i].exp_ov));
         chk($sformatf("C%0d out_channel", i), 32'(c_oc), 32'(vc[i].exp_oc));
         chk($sformatf("C%0d out_data", i), c_od, 32'hD0000000 + 32'(vc[i].exp_oc));
      end

      // Reset while a word is stalled in the buffer (rr_ptr=3 at this point)
      reset = 1'b1; c_valid = 4'b1111; c_ordy = 1'b0;
      #1;
      chk("midreset c in_ready", 32'(c_rdy), 32'h0);
      @(posedge clk); #1;
      chk("midreset c out_valid", 32'(c_ov), 32'h0);
      chk("midreset c out_data", c_od, 32'h0);
      chk("midreset c out_channel", 32'(c_oc), 32'h0);
      reset = 1'b0;
      c_valid = 4'b1010; c_ordy = 1'b1;
      #1;
      chk("postreset c in_ready", 32'(c_rdy), 32'h2);
      @(posedge clk); #1;
      chk("postreset c out_valid", 32'(c_ov), 32'h1);
      chk("postreset c out_channel", 32'(c_oc), 32'h1);
      chk("postreset c out_data", c_od, 32'hD0000001);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
